bloom_header_extractor: RTL
===========================

Name: bloom_header_extractor

Overview:
- Upstream feeder of the Bloom filter lookup stage.
- Sniffs an 8-bit Ethernet frame stream and validates EtherType/IPv4 version.
- Extracts src_ip/dest_ip, assigns a 16-bit reference tag, and queues entries in a small FIFO.
- Issues one-cycle enable pulses to the Bloom filter whenever it is not busy. Frame payload is consumed and discarded here; the payload path is elsewhere.

Parameters:
- FIFO_DEPTH, 4, number of queued {src_ip, dest_ip, tag} entries; power of 2, at least 2.
- TAG_WIDTH, 16, width of the reference tag and tag counter.
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_data  in  8  frame byte
- s_valid  in  1  byte valid
- s_last  in  1  last byte of frame
- s_ready  out  1  byte accepted when s_valid && s_ready
- bf_busy  in  1  Bloom filter busy
- bf_enable  out  1  one-cycle lookup request
- bf_src_ip  out  32  source IP, bytes 26..29, big-endian
- bf_dest_ip  out  32  destination IP, bytes 30..33, big-endian
- bf_tag  out  TAG_WIDTH  reference tag
- ipv4_count  out  CNT_WIDTH  IPv4 headers queued, saturating
- drop_count  out  CNT_WIDTH  non-IPv4 or runt frames, saturating
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State=HDR, byte_cnt=0, FIFO empty, tag counter=0.
  - bf_enable=0, bf_src_ip/bf_dest_ip/bf_tag=0, counters=0, fifo_level=0.
  - s_ready=0 during the reset cycle and 1 after.
  - Reset mid-frame discards the partial header and the FIFO contents. Bytes following reset are treated as a new frame start.
- Byte indexing: byte_cnt (6 bits) counts accepted bytes of the current frame; it increments only on a handshake.
- State HDR:
  - Byte 12 must be 0x08 and byte 13 must be 0x00. Otherwise go to DROP on that byte.
  - Byte 14 upper nibble must be 0x4. Otherwise go to DROP.
  - Bytes 26..33 are shifted into src/dest capture registers.
  - On the handshake of byte 33: push {src, dest, tag_cnt}, increment tag_cnt (wraps at 2^TAG_WIDTH-1 → 0), increment ipv4_count. Then go to PASS, or stay in HDR with byte_cnt=0 if s_last.
  - s_last accepted before byte 33 (runt): drop_count++, byte_cnt=0, stay in HDR, no push.
- State DROP: accept bytes; on s_last go to HDR with byte_cnt=0 and drop_count++.
- State PASS: accept bytes; on s_last go to HDR with byte_cnt=0.
- Backpressure:
  - s_ready=0 only when in HDR, byte_cnt==33, and the FIFO is full.
  - Otherwise s_ready=1.
  - The byte is held by the source until a pop frees space. Pop and push may occur in the same cycle.
- Issue:
  - Pop when FIFO non-empty && !bf_busy && !bf_enable.
  - bf_enable=1 for exactly one cycle, with bf_src_ip/bf_dest_ip/bf_tag registered from the popped entry.
  - Data holds until the next pop.
  - At least one idle cycle between pulses, so bf_busy has time to rise.
- Latency: byte 33 handshake at edge N → bf_enable high in cycle N+1 when FIFO was empty and bf_busy=0.
- Simultaneous push and pop: fifo_level is unchanged; order is strictly FIFO.
- Counters saturate at all-ones.
- Any frame with s_last on byte 33 counts as valid IPv4.

Test Plan:
- IPv4 frame, 60 bytes, src 0xC0A80001, dest 0x0A000002, bf_busy=0 → bf_enable single pulse 1 cycle after byte 33 with those IPs, bf_tag=0; ipv4_count=1.
- ARP frame (bytes 12..13 = 0x0806) followed by IPv4 frame → ARP gives drop_count=1 and no pulse; the IPv4 frame gets bf_tag=0.
- Runt: 20-byte frame with s_last on byte 19 → drop_count=1, no push; the next valid frame parses correctly from byte 0.
- bf_busy=1 held while 5 IPv4 frames arrive (FIFO_DEPTH=4):
  - fifo_level reaches 4 and s_ready=0 at byte 33 of frame 5.
  - Releasing bf_busy → 5 pulses, tags 0..4 in order, each separated by ≥1 idle cycle.
- tag_cnt preloaded by sending 65536 frames → tag 0xFFFF followed by 0x0000; ipv4_count saturates at 0xFFFF.
- rst asserted at byte 28 of a frame with 2 entries queued → all outputs 0, fifo_level=0; the next frame parses correctly with tag 0.

Source files
------------

// File: rtl/bloom_header_extractor.sv
// Ethernet/IPv4 header sniffer feeding the Bloom filter lookup stage.
// Extracts src/dest IPv4 addresses, tags them, queues them and issues one-cycle lookups.
module bloom_header_extractor #(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_WIDTH  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    s_data,
   input  logic                          s_valid,
   input  logic                          s_last,
   output logic                          s_ready,
   input  logic                          bf_busy,
   output logic                          bf_enable,
   output logic [31:0]                   bf_src_ip,
   output logic [31:0]                   bf_dest_ip,
   output logic [TAG_WIDTH-1:0]          bf_tag,
   output logic [CNT_WIDTH-1:0]          ipv4_count,
   output logic [CNT_WIDTH-1:0]          drop_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [5:0] IDX_ETH_HI  = 6'd12;
   localparam logic [5:0] IDX_ETH_LO  = 6'd13;
   localparam logic [5:0] IDX_VER     = 6'd14;
   localparam logic [5:0] IDX_SRC_0   = 6'd26;
   localparam logic [5:0] IDX_SRC_3   = 6'd29;
   localparam logic [5:0] IDX_DEST_0  = 6'd30;
   localparam logic [5:0] IDX_DEST_2  = 6'd32;
   localparam logic [5:0] IDX_LAST_HDR = 6'd33;

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      DROP = 2'd1,
      PASS = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0]          src;
      logic [31:0]          dest;
      logic [TAG_WIDTH-1:0] tag;
   } entry_t;

   state_t               state;
   state_t               state_next;
   logic [5:0]           byte_cnt;
   logic [31:0]          src_q;
   logic [23:0]          dest_q;
   logic [TAG_WIDTH-1:0] tag_cnt;

   entry_t               mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [LVL_W-1:0]     level;
   logic                 fifo_full;
   logic                 fifo_empty;

   logic                 hs;
   logic                 hdr_bad;
   logic                 push;
   logic                 pop;
   logic                 drop_evt;
   logic                 cap_src;
   logic                 cap_dest;
   entry_t               push_entry;

   assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (level == '0);
   assign hs         = s_valid && s_ready;
   assign fifo_level = level;

   assign hdr_bad = ((byte_cnt == IDX_ETH_HI) && (s_data != 8'h08)) ||
                    ((byte_cnt == IDX_ETH_LO) && (s_data != 8'h00)) ||
                    ((byte_cnt == IDX_VER)    && (s_data[7:4] != 4'h4));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HDR;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_next = state;
      if (hs) begin
         unique case (state)
            HDR: begin
               if (byte_cnt == IDX_LAST_HDR) begin
                  state_next = s_last ? HDR : PASS;
               end else if (s_last) begin
                  state_next = HDR;
               end else if (hdr_bad) begin
                  state_next = DROP;
               end
            end
            DROP, PASS: begin
               if (s_last) state_next = HDR;
            end
            default: state_next = HDR;
         endcase
      end
   end

   always_comb begin
      s_ready  = 1'b1;
      push     = 1'b0;
      drop_evt = 1'b0;
      cap_src  = 1'b0;
      cap_dest = 1'b0;
      // The only stall point: the last header byte cannot be accepted without FIFO space.
      if (rst || ((state == HDR) && (byte_cnt == IDX_LAST_HDR) && fifo_full)) begin
         s_ready = 1'b0;
      end
      if (hs && (state == HDR)) begin
         push     = (byte_cnt == IDX_LAST_HDR);
         drop_evt = s_last && (byte_cnt != IDX_LAST_HDR);
         cap_src  = (byte_cnt >= IDX_SRC_0)  && (byte_cnt <= IDX_SRC_3);
         cap_dest = (byte_cnt >= IDX_DEST_0) && (byte_cnt <= IDX_DEST_2);
      end
      if (hs && (state == DROP) && s_last) begin
         drop_evt = 1'b1;
      end
   end

   // -------------------------------------------------------- header capture
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt <= '0;
         src_q    <= '0;
         dest_q   <= '0;
      end else if (hs) begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         byte_cnt <= s_last ? 6'd0 : byte_cnt + 6'd1;
         if (cap_src)  src_q  <= {src_q[23:0], s_data};
         if (cap_dest) dest_q <= {dest_q[15:0], s_data};
      end
   end

   // The final destination byte goes straight into the entry being pushed.
   assign push_entry = {src_q, dest_q, s_data, tag_cnt};

   // ------------------------------------------------------------------ FIFO
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the pointers and level define which entries are valid.
      if (push) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop) begin
            level <= level + LVL_W'(1);
         end else if (pop && !push) begin
            level <= level - LVL_W'(1);
         end
      end
   end

   // ----------------------------------------------------------------- issue
   // Blocking on bf_enable guarantees an idle cycle between pulses so bf_busy can rise.
   assign pop = !fifo_empty && !bf_busy && !bf_enable;

   always_ff @(posedge clk) begin
      if (rst) begin
         bf_enable  <= 1'b0;
         bf_src_ip  <= '0;
         bf_dest_ip <= '0;
         bf_tag     <= '0;
      end else begin
         bf_enable <= pop;
         if (pop) begin
            bf_src_ip  <= mem[rd_ptr].src;
            bf_dest_ip <= mem[rd_ptr].dest;
            bf_tag     <= mem[rd_ptr].tag;
         end
      end
   end

   // ------------------------------------------------------------ statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_cnt    <= '0;
         ipv4_count <= '0;
         drop_count <= '0;
      end else begin
         if (push) begin
            tag_cnt <= tag_cnt + TAG_WIDTH'(1);
            if (ipv4_count != '1) ipv4_count <= ipv4_count + CNT_WIDTH'(1);
         end
         if (drop_evt && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule
